// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
package spi_pkg;

  localparam int SPI_BYTE_W    = 8;
  localparam int SPI_BIT_CNT_W = 3;

  function automatic logic cpol_of(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic cpha_of(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with rise/fall pulses derived
// from the synchronised level and its previous value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave oversampled in the system clock domain: MSB-first RX bytes with a
// valid pulse, and TX bytes taken from a one-entry holding buffer.
module spi_slave import spi_pkg::*; #(
  parameter int                    SPI_MODE    = 3,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [SPI_BYTE_W-1:0] i_tx_byte,
  input  logic                  i_tx_dataval,
  output logic                  o_tx_ready,
  output logic                  o_tx_underrun,
  output logic                  o_rx_dataval,
  output logic [SPI_BYTE_W-1:0] o_rx_byte,
  output logic                  o_rx_abort,
  input  logic                  i_SPI_clk,
  input  logic                  i_SPI_cs_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_oe
);

  localparam logic CPOL = cpol_of(SPI_MODE);
  localparam logic CPHA = cpha_of(SPI_MODE);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .d_i     (i_SPI_clk),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i   (i_clk),
    .rst_n_i (i_rst_n),
    .d_i     (i_SPI_cs_n),
    .level_o (cs_lvl),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  // MOSI uses the same depth as SCLK so the sampled bit lines up with the edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mosi_sync_q <= '0;
    else          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
  end

  logic mosi_s, cs_active, sclk_edge, lead_edge, trail_edge;
  logic sample, byte_start, shift_next;

  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign cs_active  = ~cs_lvl;
  assign sclk_edge  = sclk_rise | sclk_fall;
  assign lead_edge  = cs_active & sclk_edge & (sclk_lvl != CPOL);
  assign trail_edge = cs_active & sclk_edge & (sclk_lvl == CPOL);

  logic [SPI_BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [SPI_BYTE_W-1:0]    buf_q, buf_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [SPI_BYTE_W-1:0]    rx_byte_q, rx_byte_d;
  logic                     buf_full_q, buf_full_d, miso_q, miso_d;
  logic                     rx_val_q, rx_val_d, abort_q, abort_d;
  logic                     underrun_q, underrun_d;

  // A zero count at a driving edge marks the first bit of a new byte.
  assign sample     = CPHA ? trail_edge : lead_edge;
  assign byte_start = CPHA ? (lead_edge && cnt_q == '0)
                           : (cs_fall || (trail_edge && cnt_q == '0));
  assign shift_next = (CPHA ? lead_edge : trail_edge) && (cnt_q != '0);

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    tx_sr_d    = tx_sr_q;
    miso_d     = miso_q;
    rx_sr_d    = rx_sr_q;
    cnt_d      = cnt_q;
    rx_byte_d  = rx_byte_q;
    rx_val_d   = 1'b0;
    abort_d    = 1'b0;
    underrun_d = 1'b0;

    if (i_tx_dataval && !buf_full_q) begin
      buf_d      = i_tx_byte;
      buf_full_d = 1'b1;
    end

    if (byte_start) begin
      if (buf_full_q) begin
        tx_sr_d    = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_sr_d    = IDLE_BYTE;
        underrun_d = 1'b1;
      end
      miso_d = tx_sr_d[SPI_BYTE_W-1];
    end else if (shift_next) begin
      tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
      miso_d  = tx_sr_d[SPI_BYTE_W-1];
    end

    if (sample) begin
      rx_sr_d = {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
      cnt_d   = cnt_q + SPI_BIT_CNT_W'(1);
      if (cnt_q == '1) begin
        rx_byte_d = rx_sr_d;
        rx_val_d  = 1'b1;
      end
    end

    if (cs_rise) begin
      abort_d = (cnt_q != '0);
      cnt_d   = '0;
      miso_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_sr_q    <= '0;
      miso_q     <= 1'b1;
      rx_sr_q    <= '0;
      cnt_q      <= '0;
      rx_byte_q  <= '0;
      rx_val_q   <= 1'b0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_sr_q    <= tx_sr_d;
      miso_q     <= miso_d;
      rx_sr_q    <= rx_sr_d;
      cnt_q      <= cnt_d;
      rx_byte_q  <= rx_byte_d;
      rx_val_q   <= rx_val_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
    end
  end

  assign o_tx_ready    = ~buf_full_q;
  assign o_tx_underrun = underrun_q;
  assign o_rx_dataval  = rx_val_q;
  assign o_rx_byte     = rx_byte_q;
  assign o_rx_abort    = abort_q;
  assign o_SPI_MISO    = miso_q;
  assign o_SPI_MISO_oe = cs_active;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode, a bit-level master model and
// a user-side byte feeder, checked against an in-order byte-consumption model.
module tb_spi_slave;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0] tx_byte [4];
  logic       tx_dv [4];
  logic       tx_ready [4];
  logic       underrun [4];
  logic       rx_val [4];
  logic [7:0] rx_byte [4];
  logic       rx_abort [4];
  logic       sclk [4];
  logic       cs_n [4];
  logic       mosi [4];
  logic       miso [4];
  logic       miso_oe [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_tx_byte     (tx_byte[g]),
      .i_tx_dataval  (tx_dv[g]),
      .o_tx_ready    (tx_ready[g]),
      .o_tx_underrun (underrun[g]),
      .o_rx_dataval  (rx_val[g]),
      .o_rx_byte     (rx_byte[g]),
      .o_rx_abort    (rx_abort[g]),
      .i_SPI_clk     (sclk[g]),
      .i_SPI_cs_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_oe (miso_oe[g])
    );
  end

  int checks = 0;
  int failures = 0;

  // User side: bytes queued per mode, offered in order whenever the DUT is ready.
  logic [7:0] feed [4][256];
  int feed_n [4];
  int feed_i [4];
  logic rdy_seen [4];

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (tx_dv[m] === 1'b1 && rdy_seen[m] === 1'b1) feed_i[m]++;
      tx_dv[m]    = (feed_i[m] < feed_n[m]);
      tx_byte[m]  = feed[m][feed_i[m] % 256];
      rdy_seen[m] = tx_ready[m];
    end
  end

  // Output monitor.
  logic [7:0] rx_log [4][16];
  int rx_cnt [4];
  int ur_cnt [4];
  int ab_cnt [4];
  int rdy_low [4];

  always @(negedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_val[m] === 1'b1) begin
        rx_log[m][rx_cnt[m] % 16] = rx_byte[m];
        rx_cnt[m]++;
      end
      if (underrun[m] === 1'b1) ur_cnt[m]++;
      if (rx_abort[m] === 1'b1) ab_cnt[m]++;
      if (tx_ready[m] === 1'b0) rdy_low[m]++;
    end
  end

  // Reference state: user bytes consumed so far, last good received byte.
  int mp [4];
  logic [7:0] exp_rxb [4];
  logic [7:0] m_tx [4];
  logic [7:0] m_rx [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half_bit();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push(input int m, input logic [7:0] b);
    feed[m][feed_n[m] % 256] = b;
    feed_n[m]++;
  endtask

  task automatic xfer(input int m, input int nbits);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    for (int k = 0; k < 4; k++) m_rx[k] = 8'h00;
    repeat (4) @(negedge clk);
    cs_n[m] = 1'b0;
    if (!cpha) mosi[m] = m_tx[0][7];
    half_bit();
    for (int b = 0; b < nbits; b++) begin
      if (cpha) mosi[m] = m_tx[b / 8][7 - (b % 8)];
      sclk[m] = ~cpol;
      if (!cpha) m_rx[b / 8][7 - (b % 8)] = miso[m];
      half_bit();
      sclk[m] = cpol;
      if (cpha) m_rx[b / 8][7 - (b % 8)] = miso[m];
      if (!cpha && b + 1 < nbits) mosi[m] = m_tx[(b + 1) / 8][7 - ((b + 1) % 8)];
      half_bit();
    end
    cs_n[m] = 1'b1;
    half_bit();
    half_bit();
  endtask

  task automatic xfer_check(input int m, input int nbits, input string tag);
    int nfull, starts, exp_ur, b_rx, b_ur, b_ab;
    logic [7:0] exp_miso [4];
    logic cpha;
    cpha   = (m % 2) == 1;
    nfull  = nbits / 8;
    starts = cpha ? (nbits + 7) / 8 : 1 + nfull;
    exp_ur = 0;
    for (int k = 0; k < starts; k++) begin
      logic [7:0] b;
      if (mp[m] < feed_n[m]) begin
        b = feed[m][mp[m] % 256];
        mp[m]++;
      end else begin
        b = 8'hFF;
        exp_ur++;
      end
      if (k < 4) exp_miso[k] = b;
    end
    b_rx = rx_cnt[m];
    b_ur = ur_cnt[m];
    b_ab = ab_cnt[m];
    xfer(m, nbits);
    for (int k = 0; k < nfull; k++) begin
      chk($sformatf("%s_m%0d_miso%0d", tag, m, k), 32'(m_rx[k]), 32'(exp_miso[k]));
      chk($sformatf("%s_m%0d_rx%0d", tag, m, k), 32'(rx_log[m][(b_rx + k) % 16]), 32'(m_tx[k]));
    end
    if (nfull > 0) exp_rxb[m] = m_tx[nfull - 1];
    chk($sformatf("%s_m%0d_nrx", tag, m), 32'(rx_cnt[m] - b_rx), 32'(nfull));
    chk($sformatf("%s_m%0d_abort", tag, m), 32'(ab_cnt[m] - b_ab), 32'((nbits % 8) != 0));
    chk($sformatf("%s_m%0d_underrun", tag, m), 32'(ur_cnt[m] - b_ur), 32'(exp_ur));
    chk($sformatf("%s_m%0d_rxbyte", tag, m), 32'(rx_byte[m]), 32'(exp_rxb[m]));
    chk($sformatf("%s_m%0d_ready", tag, m), 32'(tx_ready[m]), 32'(mp[m] >= feed_n[m]));
    chk($sformatf("%s_m%0d_idle", tag, m), {30'd0, miso_oe[m], miso[m]}, 32'b01);
  endtask

  task automatic chk_reset(input int m, input string tag);
    chk({tag, "_ready"}, 32'(tx_ready[m]), 32'd1);
    chk({tag, "_underrun"}, 32'(underrun[m]), 32'd0);
    chk({tag, "_rxval"}, 32'(rx_val[m]), 32'd0);
    chk({tag, "_rxbyte"}, 32'(rx_byte[m]), 32'd0);
    chk({tag, "_abort"}, 32'(rx_abort[m]), 32'd0);
    chk({tag, "_miso"}, 32'(miso[m]), 32'd1);
    chk({tag, "_oe"}, 32'(miso_oe[m]), 32'd0);
  endtask

  initial begin
    int b_rl, m, n, u;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sclk[k]    = (k >= 2);
      cs_n[k]    = 1'b1;
      mosi[k]    = 1'b0;
      exp_rxb[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk_reset(3, "reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0, "reset_rel");

    // Mode 3 basic exchange.
    push(3, 8'hA5);
    repeat (4) @(negedge clk);
    chk("preload_ready", 32'(tx_ready[3]), 32'd0);
    m_tx[0] = 8'h3C;
    xfer_check(3, 8, "basic");

    // Remaining modes.
    for (int k = 0; k < 3; k++) begin
      push(k, 8'h7E);
      m_tx[0] = 8'h81;
      xfer_check(k, 8, "mode");
    end

    // Back-to-back bytes under one CS with continuous reloads.
    for (int k = 0; k < 3; k++) push(3, 8'($urandom));
    m_tx[0] = 8'h01; m_tx[1] = 8'h02; m_tx[2] = 8'h03;
    xfer_check(3, 24, "b2b");

    // No user byte: idle byte and a single underrun.
    b_rl = rdy_low[3];
    m_tx[0] = 8'($urandom);
    xfer_check(3, 8, "underrun");
    chk("underrun_ready_stays", 32'(rdy_low[3] - b_rl), 32'd0);

    // Partial byte then a clean one.
    m_tx[0] = 8'($urandom);
    xfer_check(3, 5, "abort");
    m_tx[0] = 8'hC3;
    xfer_check(3, 8, "after_abort");

    // Randomised transfers across all modes.
    for (int it = 0; it < 14; it++) begin
      m = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      u = $urandom_range(0, n + 1);
      for (int k = 0; k < u; k++) push(m, 8'($urandom));
      for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
      xfer_check(m, n * 8, $sformatf("rnd%0d", it));
    end

    // Drain any leftover user bytes so a reset cannot discard a modelled byte.
    for (int k = 0; k < 4; k++) begin
      m_tx[0] = 8'($urandom);
      xfer_check(k, 8, "drain");
      for (int d = 0; d < 4 && mp[k] < feed_n[k]; d++) xfer_check(k, 8, "drain_x");
    end

    // Reset in the middle of a byte; held until the master has finished.
    m_tx[0] = 8'($urandom);
    fork
      xfer(3, 8);
      begin
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset(3, "rst_mid");
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) exp_rxb[k] = 8'h00;
    repeat (4) @(negedge clk);
    chk_reset(3, "rst_after");
    m_tx[0] = 8'h5A;
    push(3, 8'($urandom));
    xfer_check(3, 8, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
